// File: rtl/eq_pkg.sv
// Shared types and constants for the pot scan scheduler.
package eq_pkg;

  localparam int NUM_POTS = 6;

  typedef enum logic [2:0] {
    StIdle,
    StArb,
    StStart,
    StWait,
    StGap
  } state_e;

  // A2D channel for each scan slot: LP, B1, B2, B3, HP, volume.
  localparam logic [2:0] SLOT_CHNL [NUM_POTS] = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7};

  // Slot index to A2D channel; out-of-range slots map to channel 0.
  function automatic logic [2:0] slot_chnl(input logic [2:0] slot);
    logic [2:0] ch;
    ch = '0;
    for (int i = 0; i < NUM_POTS; i++) begin
      if (slot == 3'(i)) ch = SLOT_CHNL[i];
    end
    return ch;
  endfunction

endpackage

// File: rtl/gap_timer.sv
// Loadable down-counter with a zero flag; used for both gap and WAIT timeout counting.
module gap_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  // Load takes priority; otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  // Counter state with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pot_scan_sched.sv
// Round-robin scheduler sharing one A2D among six slide pots and a debug requester.
module pot_scan_sched
  import eq_pkg::*;
#(
  parameter int unsigned CNV_GAP   = 16,
  parameter int unsigned SWEEP_GAP = 1024,
  parameter int unsigned TIMEOUT   = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  input  logic        cnv_cmplt,
  input  logic [11:0] res,
  output logic [11:0] LP_pot,
  output logic [11:0] B1_pot,
  output logic [11:0] B2_pot,
  output logic [11:0] B3_pot,
  output logic [11:0] HP_pot,
  output logic [11:0] volume,
  output logic [5:0]  pot_vld,
  output logic        sweep_done,
  input  logic        dbg_req,
  input  logic [2:0]  dbg_chnl,
  output logic        dbg_ack,
  output logic [11:0] dbg_res,
  output logic        timeout_err
);

  localparam int unsigned MaxAB   = (TIMEOUT > CNV_GAP) ? TIMEOUT : CNV_GAP;
  localparam int unsigned MaxLoad = (MaxAB > SWEEP_GAP) ? MaxAB : SWEEP_GAP;
  // Loaded values never exceed MaxLoad-1.
  localparam int unsigned CntW    = (MaxLoad < 2) ? 1 : $clog2(MaxLoad);

  state_e      state_q;
  logic [2:0]  slot_q;
  logic        dbg_q;       // current/most recent conversion was a debug grant
  logic        strt_cnv_q;
  logic [2:0]  chnnl_q;
  logic [11:0] pot_q [NUM_POTS];
  logic [5:0]  pot_vld_q;
  logic        sweep_done_q;
  logic        dbg_ack_q;
  logic [11:0] dbg_res_q;
  logic        timeout_err_q;

  logic            tmr_load;
  logic [CntW-1:0] tmr_val;
  logic            tmr_zero;
  logic            wait_done;
  logic            sweep_end;
  logic            gap_zero;

  // A scheduled slot 5 conversion closes a sweep and earns the long gap.
  assign sweep_end = !dbg_q && (slot_q == 3'(NUM_POTS - 1));
  // Completion wins over a simultaneous timeout expiry.
  assign wait_done = (state_q == StWait) && (cnv_cmplt || tmr_zero);
  assign gap_zero  = sweep_end ? (SWEEP_GAP == 0) : (CNV_GAP == 0);

  // Timer loads: timeout budget on START, gap length when leaving WAIT.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (state_q == StStart) begin
      tmr_load = 1'b1;
      tmr_val  = CntW'(TIMEOUT - 1);
    end else if (wait_done && !gap_zero) begin
      tmr_load = 1'b1;
      tmr_val  = sweep_end ? CntW'(SWEEP_GAP - 1) : CntW'(CNV_GAP - 1);
    end
  end

  gap_timer #(
    .Width(CntW)
  ) u_gap_timer (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .zero_o    (tmr_zero)
  );

  // Scheduler FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      slot_q        <= '0;
      dbg_q         <= 1'b0;
      strt_cnv_q    <= 1'b0;
      chnnl_q       <= '0;
      pot_vld_q     <= '0;
      sweep_done_q  <= 1'b0;
      dbg_ack_q     <= 1'b0;
      dbg_res_q     <= '0;
      timeout_err_q <= 1'b0;
      for (int i = 0; i < NUM_POTS; i++) pot_q[i] <= '0;
    end else begin
      strt_cnv_q   <= 1'b0;
      sweep_done_q <= 1'b0;
      dbg_ack_q    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (en) state_q <= StArb;
        end
        StArb: begin
          // Debug never takes two conversions in a row.
          if (dbg_req && !dbg_q) begin
            dbg_q   <= 1'b1;
            chnnl_q <= dbg_chnl;
          end else begin
            dbg_q   <= 1'b0;
            chnnl_q <= slot_chnl(slot_q);
          end
          strt_cnv_q <= 1'b1;
          state_q    <= StStart;
        end
        StStart: begin
          state_q <= StWait;
        end
        StWait: begin
          if (wait_done) begin
            if (cnv_cmplt) begin
              if (dbg_q) begin
                dbg_res_q <= res;
              end else begin
                for (int i = 0; i < NUM_POTS; i++) begin
                  if (slot_q == 3'(i)) begin
                    pot_q[i]     <= res;
                    pot_vld_q[i] <= 1'b1;
                  end
                end
              end
            end else begin
              timeout_err_q <= 1'b1;
            end
            if (dbg_q) begin
              dbg_ack_q <= 1'b1;
            end else begin
              slot_q       <= sweep_end ? 3'd0 : slot_q + 3'd1;
              sweep_done_q <= sweep_end;
            end
            if (gap_zero) begin
              state_q <= en ? StArb : StIdle;
            end else begin
              state_q <= StGap;
            end
          end
        end
        StGap: begin
          if (tmr_zero) state_q <= en ? StArb : StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign strt_cnv    = strt_cnv_q;
  assign chnnl       = chnnl_q;
  assign LP_pot      = pot_q[0];
  assign B1_pot      = pot_q[1];
  assign B2_pot      = pot_q[2];
  assign B3_pot      = pot_q[3];
  assign HP_pot      = pot_q[4];
  assign volume      = pot_q[5];
  assign pot_vld     = pot_vld_q;
  assign sweep_done  = sweep_done_q;
  assign dbg_ack     = dbg_ack_q;
  assign dbg_res     = dbg_res_q;
  assign timeout_err = timeout_err_q;

endmodule
